pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the fixed-width EX/MEM latch and can be instantiated at any stage boundary, selected by the STAGE index into the global stall vector. It carries the GPR write-back payload and the HI/LO payload, and adds a valid bit and a synchronous flush. It also carries a multi-cycle temp side channel (madd/msub/div partial result and cycle count) that survives stalls. Saturating stall and bubble performance counters are included.

---
 rtl/pipe_stage_reg.sv | 187 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/flush, a
// multi-cycle temp side channel and saturating stall/bubble counters.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   stall[STALL_W]     global stall vector; stall[STAGE] is upstream,
//                      stall[STAGE+1] is downstream
//   flush              kill the in-flight instruction and multi-cycle op
//   in_*  / out_*      GPR and HI/LO write-back payload plus valid
//   tmp_i/cnt_i        multi-cycle partial result and step from upstream
//   tmp_o/cnt_o        registered partial result and step fed back
//   stall_cycles       saturating count of cycles with upstream stalled
//   bubble_cnt         saturating count of inserted bubbles

module pipe_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int TMP_W   = 64,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int PERF_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_wreg,
  input  logic [ADDR_W-1:0]  in_wd,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic               in_whilo,
  input  logic [DATA_W-1:0]  in_hi,
  input  logic [DATA_W-1:0]  in_lo,
  input  logic [TMP_W-1:0]   tmp_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               out_valid,
  output logic               out_wreg,
  output logic [ADDR_W-1:0]  out_wd,
  output logic [DATA_W-1:0]  out_wdata,
  output logic               out_whilo,
  output logic [DATA_W-1:0]  out_hi,
  output logic [DATA_W-1:0]  out_lo,
  output logic [TMP_W-1:0]   tmp_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [PERF_W-1:0]  stall_cycles,
  output logic [PERF_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic [ADDR_W-1:0] wd;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } pay_t;

  localparam logic [PERF_W-1:0] PERF_ONE = 1;

  logic up;
  logic dn;

  assign up = stall[STAGE];

  // The last stage has no downstream stall bit.
  generate
    if (STAGE == STALL_W - 1) begin : g_last
      assign dn = 1'b0;
    end else begin : g_mid
      assign dn = stall[STAGE+1];
    end
  endgenerate

  // One-hot cycle action; flush outranks every stall case.
  logic do_flush;
  logic do_bub;
  logic do_adv;
  logic do_hold;

  assign do_flush = flush;
  assign do_bub   = !flush && up && !dn;
  assign do_adv   = !flush && !up;
  assign do_hold  = !flush && up && dn;

  pay_t             pay_q;
  pay_t             pay_d;
  pay_t             pay_in;
  logic [TMP_W-1:0] tmp_q;
  logic [TMP_W-1:0] tmp_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Invalid instructions are captured as an all-zero payload so
  // nothing stale leaks into write-back.
  always_comb begin
    pay_in       = '0;
    pay_in.valid = in_valid;
    if (in_valid) begin
      pay_in.wreg  = in_wreg;
      pay_in.wd    = in_wd;
      pay_in.wdata = in_wdata;
      pay_in.whilo = in_whilo;
      pay_in.hi    = in_hi;
      pay_in.lo    = in_lo;
    end
  end

  always_comb begin
    pay_d = pay_q;
    tmp_d = tmp_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      do_flush: begin
        pay_d = '0;
        tmp_d = '0;
        cnt_d = '0;
      end
      do_bub: begin
        pay_d = '0;
        tmp_d = tmp_i;
        cnt_d = cnt_i;
      end
      do_adv: begin
        pay_d = pay_in;
        tmp_d = '0;
        cnt_d = '0;
      end
      do_hold: begin
        tmp_d = tmp_i;
        cnt_d = cnt_i;
      end
      default: begin
        pay_d = pay_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pay_q <= '0;
      tmp_q <= '0;
      cnt_q <= '0;
    end else begin
      pay_q <= pay_d;
      tmp_q <= tmp_d;
      cnt_q <= cnt_d;
    end
  end

  logic [PERF_W-1:0] sc_q;
  logic [PERF_W-1:0] bc_q;
  logic              sc_inc;
  logic              bc_inc;

  // Flush cycles still count as stalled, but no bubble is inserted.
  assign sc_inc = up && !(&sc_q);
  assign bc_inc = do_bub && !(&bc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      bc_q <= '0;
    end else begin
      if (sc_inc) begin
        sc_q <= sc_q + PERF_ONE;
      end
      if (bc_inc) begin
        bc_q <= bc_q + PERF_ONE;
      end
    end
  end

  assign out_valid    = pay_q.valid;
  assign out_wreg     = pay_q.wreg;
  assign out_wd       = pay_q.wd;
  assign out_wdata    = pay_q.wdata;
  assign out_whilo    = pay_q.whilo;
  assign out_hi       = pay_q.hi;
  assign out_lo       = pay_q.lo;
  assign tmp_o        = tmp_q;
  assign cnt_o        = cnt_q;
  assign stall_cycles = sc_q;
  assign bubble_cnt   = bc_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: reset, advance, bubble, hold,
// flush, valid gating and counter saturation on a PERF_W=4 instance.

module tb_pipe_stage_reg;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    logic [15:0] sc;
    logic [15:0] bc;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [5:0]  sat_stall;
  logic        flush;
  logic        in_valid;
  logic        in_wreg;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata;
  logic        in_whilo;
  logic [31:0] in_hi;
  logic [31:0] in_lo;
  logic [63:0] tmp_i;
  logic [1:0]  cnt_i;

  logic        out_valid;
  logic        out_wreg;
  logic [4:0]  out_wd;
  logic [31:0] out_wdata;
  logic        out_whilo;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic [63:0] tmp_o;
  logic [1:0]  cnt_o;
  logic [15:0] stall_cycles;
  logic [15:0] bubble_cnt;

  logic        s_valid;
  logic        s_wreg;
  logic [4:0]  s_wd;
  logic [31:0] s_wdata;
  logic        s_whilo;
  logic [31:0] s_hi;
  logic [31:0] s_lo;
  logic [63:0] s_tmp;
  logic [1:0]  s_cnt;
  logic [3:0]  s_sc;
  logic [3:0]  s_bc;

  int n_chk;
  int n_fail;
  int exp_sc;
  int exp_bc;
  obs_t sb[$];

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd),
    .in_wdata(in_wdata), .in_whilo(in_whilo),
    .in_hi(in_hi), .in_lo(in_lo),
    .tmp_i(tmp_i), .cnt_i(cnt_i),
    .out_valid(out_valid), .out_wreg(out_wreg), .out_wd(out_wd),
    .out_wdata(out_wdata), .out_whilo(out_whilo),
    .out_hi(out_hi), .out_lo(out_lo),
    .tmp_o(tmp_o), .cnt_o(cnt_o),
    .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.PERF_W(4)) u_sat (
    .clk(clk), .rst(rst), .stall(sat_stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd),
    .in_wdata(in_wdata), .in_whilo(in_whilo),
    .in_hi(in_hi), .in_lo(in_lo),
    .tmp_i(tmp_i), .cnt_i(cnt_i),
    .out_valid(s_valid), .out_wreg(s_wreg), .out_wd(s_wd),
    .out_wdata(s_wdata), .out_whilo(s_whilo),
    .out_hi(s_hi), .out_lo(s_lo),
    .tmp_o(s_tmp), .cnt_o(s_cnt),
    .stall_cycles(s_sc), .bubble_cnt(s_bc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t snap();
    obs_t o;
    o = {out_valid, out_wreg, out_wd, out_wdata, out_whilo,
         out_hi, out_lo, tmp_o, cnt_o, stall_cycles, bubble_cnt};
    return o;
  endfunction

  function automatic obs_t mk(
    input logic v, input logic w, input logic [4:0] wd,
    input logic [31:0] wdat, input logic wh,
    input logic [31:0] hi, input logic [31:0] lo,
    input logic [63:0] t, input logic [1:0] c);
    obs_t o;
    o = {v, w, wd, wdat, wh, hi, lo, t, c,
         16'(exp_sc), 16'(exp_bc)};
    return o;
  endfunction

  task automatic set_in(
    input logic v, input logic w, input logic [4:0] wd,
    input logic [31:0] wdat, input logic wh,
    input logic [31:0] hi, input logic [31:0] lo);
    in_valid = v;
    in_wreg  = w;
    in_wd    = wd;
    in_wdata = wdat;
    in_whilo = wh;
    in_hi    = hi;
    in_lo    = lo;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t exp;
    rst   = 1'b1;
    stall = 6'b111111;
    sat_stall = 6'b111111;
    flush = 1'b0;
    set_in(1, 1, 5'd31, 32'hFFFF_FFFF, 1, 32'h5555, 32'hAAAA);
    tmp_i = 64'h1234_5678_9ABC_DEF0;
    cnt_i = 2'd3;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('0);
      tick();
      got = snap();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    rst = 1'b0;
    stall = 6'b0;
    sat_stall = 6'b0;
    exp_sc = 0;
    exp_bc = 0;
  endtask

  task automatic test_advance();
    obs_t got;
    obs_t exp;
    stall = 6'b0;
    set_in(1, 1, 5'd7, 32'hDEAD_BEEF, 1, 32'h1, 32'h2);
    tmp_i = 64'hFFFF_0000_FFFF_0000;
    cnt_i = 2'd2;
    sb.push_back(mk(1, 1, 5'd7, 32'hDEAD_BEEF, 1,
                    32'h1, 32'h2, 64'h0, 2'd0));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL advance got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_bubble();
    obs_t got;
    obs_t exp;
    stall = 6'b001000;
    tmp_i = 64'h0000_0001_0000_0002;
    for (int i = 0; i < 3; i++) begin
      cnt_i = 2'(i);
      exp_sc++;
      exp_bc++;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, tmp_i, 2'(i)));
      tick();
      got = snap();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL bubble[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    n_chk++;
    if (bubble_cnt !== 16'd3 || stall_cycles !== 16'd3) begin
      n_fail++;
      $display("FAIL bubble_counts got=%0d/%0d exp=3/3",
               bubble_cnt, stall_cycles);
    end
  endtask

  task automatic test_hold();
    obs_t got;
    obs_t exp;
    stall = 6'b0;
    set_in(1, 1, 5'd9, 32'hAAAA_5555, 0, 32'h3, 32'h4);
    sb.push_back(mk(1, 1, 5'd9, 32'hAAAA_5555, 0,
                    32'h3, 32'h4, 64'h0, 2'd0));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL hold_load got=%h exp=%h", got, exp);
    end
    stall = 6'b011000;
    set_in(1, 0, 5'd1, 32'h1111_1111, 1, 32'h7, 32'h8);
    for (int i = 0; i < 4; i++) begin
      tmp_i = 64'h100 + 64'(i);
      cnt_i = 2'(3 - i);
      exp_sc++;
      sb.push_back(mk(1, 1, 5'd9, 32'hAAAA_5555, 0,
                      32'h3, 32'h4, tmp_i, cnt_i));
      tick();
      got = snap();
      exp = sb.pop_front();
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_flush();
    obs_t got;
    obs_t exp;
    stall = 6'b001000;
    tmp_i = 64'hCAFE_F00D_0000_0042;
    cnt_i = 2'b01;
    exp_sc++;
    exp_bc++;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, tmp_i, 2'b01));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_setup got=%h exp=%h", got, exp);
    end
    flush = 1'b1;
    cnt_i = 2'b10;
    exp_sc++;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 2'b00));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_bubble got=%h exp=%h", got, exp);
    end
    stall = 6'b0;
    flush = 1'b0;
    set_in(1, 1, 5'd12, 32'h0BAD_F00D, 1, 32'h9, 32'hA);
    sb.push_back(mk(1, 1, 5'd12, 32'h0BAD_F00D, 1,
                    32'h9, 32'hA, 64'h0, 2'd0));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_reload got=%h exp=%h", got, exp);
    end
    stall = 6'b011000;
    flush = 1'b1;
    exp_sc++;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 2'b00));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL flush_hold got=%h exp=%h", got, exp);
    end
    flush = 1'b0;
    stall = 6'b0;
  endtask

  task automatic test_gating();
    obs_t got;
    obs_t exp;
    stall = 6'b0;
    set_in(0, 1, 5'd3, 32'h1234_5678, 1, 32'h11, 32'h22);
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 64'h0, 2'd0));
    tick();
    got = snap();
    exp = sb.pop_front();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL gating got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_saturation();
    int e;
    stall = 6'b0;
    sat_stall = 6'b001000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = (i > 15) ? 15 : i;
      n_chk++;
      if (s_sc !== 4'(e) || s_bc !== 4'(e)) begin
        n_fail++;
        $display("FAIL saturation[%0d] got=%h/%h exp=%h",
                 i, s_sc, s_bc, 4'(e));
      end
    end
    sat_stall = 6'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_sc = 0;
    exp_bc = 0;
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_gating();
    test_saturation();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
